// File: rtl/inst_prefetch_buf.sv
// Instruction prefetch queue: issues sequential word fetches, buffers returned
// words with their PCs, and hands them to the core over a valid/ready handshake.
module inst_prefetch_buf #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [31:0] flush_addr_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_ready_i
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   outst_q, outst_d;
    logic [CNT_W-1:0]   stale_q, stale_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   trk_wr_q, trk_wr_d;
    logic [PTR_W-1:0]   trk_rd_q, trk_rd_d;
    logic               flush_q;

    logic [31:0]        fifo_inst_q [DEPTH];
    logic [31:0]        fifo_pc_q   [DEPTH];
    logic [31:0]        trk_pc_q    [DEPTH];

    logic               gnt;
    logic               rvalid_eff;
    logic               push;
    logic               pop;
    logic [OCC_W-1:0]   occupancy;

    // Requests in flight plus buffered words never exceed DEPTH, so a push never overflows.
    assign occupancy  = OCC_W'(count_q) + OCC_W'(outst_q);
    assign gnt        = mem_req_o && mem_gnt_i;
    assign rvalid_eff = mem_rvalid_i && (outst_q != '0);
    assign push       = rvalid_eff && (stale_q == '0) && !flush_i;
    assign pop        = inst_valid_o && inst_ready_i && !flush_i;
    assign mem_addr_o = fetch_pc_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a redirect overrides every state including BOOT
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = (stale_d != '0) ? S_DRAIN : S_FETCH;
        end else begin
            case (state_q)
                S_BOOT:  state_d = S_FETCH;
                S_FETCH: state_d = S_FETCH;
                S_DRAIN: if (stale_d == '0) state_d = S_FETCH;
                default: state_d = S_BOOT;
            endcase
        end
    end

    // Request output; a held redirect suppresses issue from its second cycle on
    always_comb begin
        mem_req_o = 1'b0;
        if ((state_q == S_FETCH) && (occupancy < DEPTH_OCC) && !(flush_i && flush_q)) begin
            mem_req_o = 1'b1;
        end
    end

    // Counter, pointer and fetch-PC updates
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        stale_d    = stale_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        trk_wr_d   = trk_wr_q;
        trk_rd_d   = trk_rd_q;
        outst_d    = outst_q + CNT_W'(gnt) - CNT_W'(rvalid_eff);

        if (gnt)        trk_wr_d = trk_wr_q + PTR_W'(1);
        if (rvalid_eff) trk_rd_d = trk_rd_q + PTR_W'(1);

        if (flush_i) begin
            fetch_pc_d = {flush_addr_i[31:2], 2'b00};
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            stale_d    = outst_d;
        end else begin
            if (gnt)  fetch_pc_d = fetch_pc_q + 32'd4;
            if (push) wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (rvalid_eff && (stale_q != '0)) stale_d = stale_q - CNT_W'(1);
        end
    end

    // Control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            stale_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            trk_wr_q   <= '0;
            trk_rd_q   <= '0;
            flush_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            stale_q    <= stale_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            trk_wr_q   <= trk_wr_d;
            trk_rd_q   <= trk_rd_d;
            flush_q    <= flush_i;
        end
    end

    // Storage: in-flight PC tracker and the instruction FIFO; only read behind valid pointers
    always_ff @(posedge clk) begin
        if (gnt) begin
            trk_pc_q[trk_wr_q] <= fetch_pc_q;
        end
        if (push) begin
            fifo_inst_q[wr_ptr_q] <= mem_rdata_i;
            fifo_pc_q[wr_ptr_q]   <= trk_pc_q[trk_rd_q];
        end
    end

    // Core-facing head of the FIFO
    always_comb begin
        inst_valid_o = (count_q != '0);
        inst_o       = NOP_INST;
        inst_addr_o  = '0;
        if (inst_valid_o) begin
            inst_o      = fifo_inst_q[rd_ptr_q];
            inst_addr_o = fifo_pc_q[rd_ptr_q];
        end
    end

`ifndef SYNTHESIS
    a_rvalid_has_request: assert property (@(posedge clk) disable iff (rst)
        mem_rvalid_i |-> (outst_q != '0))
        else $error("rvalid received with no request outstanding");
`endif

endmodule

// File: tb/tb_inst_prefetch_buf.sv
// Directed bench for inst_prefetch_buf: a latency-controlled memory responder and a
// scoreboard of granted addresses checked in order as the core pops instructions.
module tb_inst_prefetch_buf;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic [31:0] flush_addr_i = 32'h0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_ready_i = 1'b0;

    always #5 clk = ~clk;

    inst_prefetch_buf #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000),
        .NOP_INST (NOP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .flush_addr_i (flush_addr_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_ready_i (inst_ready_i)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        rq[$];
    logic [31:0] exp_q[$];
    int          cyc = 0;
    int          lat = 1;
    int          n_pass = 0;
    int          n_fail = 0;
    int          n_total = 0;
    int          n_grants = 0;
    int          g0 = 0;
    bit          hold_resp = 1'b0;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // First half of a cycle: memory responder drives rvalid, outputs settle
    task automatic pre();
        if (!hold_resp && rq.size() != 0 && rq[0].due <= cyc) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = data_of(rq[0].addr);
        end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = 32'h0;
        end
        #1;
    endtask

    // Second half: account for the events the coming edge will commit
    task automatic post();
        logic        g;
        logic [31:0] e;
        g = mem_req_o && mem_gnt_i;
        if (mem_rvalid_i) void'(rq.pop_front());
        if (!flush_i && inst_valid_o && inst_ready_i) begin
            chk1("sb_pop_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pop_pc", inst_addr_o, e);
                chk("pop_inst", inst_o, data_of(e));
            end
        end
        if (g) begin
            rq.push_back('{mem_addr_o, cyc + lat});
            exp_q.push_back(mem_addr_o);
            n_grants++;
        end
        if (flush_i) exp_q.delete();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic step();
        pre();
        post();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        flush_i      = 1'b0;
        mem_rvalid_i = 1'b0;
        hold_resp    = 1'b0;
        rq.delete();
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b0;
        cyc      = 1;
        n_grants = 0;
    endtask

    // Leaves the bench in the middle of the cycle where mem_req_o is first seen high
    task automatic wait_req(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pre();
            if (mem_req_o) begin
                ok = 1'b1;
                break;
            end
            post();
        end
        chk1(tag, ok, 1'b1);
        if (!ok) pre();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        mem_gnt_i    = 1'b1;
        inst_ready_i = 1'b1;

        // Reset values
        @(negedge clk);
        #1;
        chk1("rst_req", mem_req_o, 1'b0);
        chk("rst_addr", mem_addr_o, 32'h0);
        chk1("rst_valid", inst_valid_o, 1'b0);
        chk("rst_inst", inst_o, NOP);
        chk("rst_pc", inst_addr_o, 32'h0);

        // Streaming after reset release
        do_reset();
        pre(); chk1("boot_no_req", mem_req_o, 1'b0); post();
        pre(); chk1("first_req", mem_req_o, 1'b1); chk("first_addr", mem_addr_o, 32'h0); post();
        step();
        for (int i = 0; i < 8; i++) begin
            pre();
            chk1("stream_valid", inst_valid_o, 1'b1);
            chk("stream_pc", inst_addr_o, 32'(i * 4));
            post();
        end

        // Core stalled: queue fills, then one pop frees one request slot
        do_reset();
        inst_ready_i = 1'b0;
        run(12);
        chk("full_grants", 32'(n_grants), 32'd4);
        pre();
        chk1("full_no_req", mem_req_o, 1'b0);
        chk1("full_head_valid", inst_valid_o, 1'b1);
        chk("full_head_pc", inst_addr_o, 32'h0);
        post();
        inst_ready_i = 1'b1;
        step();
        inst_ready_i = 1'b0;
        pre();
        chk1("refill_req", mem_req_o, 1'b1);
        chk("refill_addr", mem_addr_o, 32'h10);
        chk("refill_head_pc", inst_addr_o, 32'h4);
        post();
        chk("refill_grants", 32'(n_grants), 32'd5);

        // Redirect with two responses outstanding
        do_reset();
        inst_ready_i = 1'b1;
        hold_resp    = 1'b1;
        run(3);
        mem_gnt_i    = 1'b0;
        flush_i      = 1'b1;
        flush_addr_i = 32'h0000_0103;
        step();
        flush_i   = 1'b0;
        mem_gnt_i = 1'b1;
        pre(); chk1("drain_no_req", mem_req_o, 1'b0); chk1("drain_empty", inst_valid_o, 1'b0); post();
        hold_resp = 1'b0;
        pre(); chk1("drop1_no_req", mem_req_o, 1'b0); post();
        pre(); chk1("drop2_no_req", mem_req_o, 1'b0); post();
        pre();
        chk1("redirect_req", mem_req_o, 1'b1);
        chk("redirect_addr", mem_addr_o, 32'h100);
        chk1("dropped_not_pushed", inst_valid_o, 1'b0);
        post();
        step();
        pre(); chk1("redirect_valid", inst_valid_o, 1'b1); chk("redirect_first_pc", inst_addr_o, 32'h100); post();

        // Flush coinciding with rvalid, grant and pop
        run(3);
        flush_i      = 1'b1;
        flush_addr_i = 32'h0000_0200;
        pre();
        chk1("t4_pre_valid", inst_valid_o, 1'b1);
        chk1("t4_pre_req", mem_req_o, 1'b1);
        post();
        flush_i = 1'b0;
        pre();
        chk1("t4_empty", inst_valid_o, 1'b0);
        chk("t4_inst_nop", inst_o, NOP);
        chk1("t4_stale_drain", mem_req_o, 1'b0);
        post();
        pre(); chk1("t4_req", mem_req_o, 1'b1); chk("t4_addr", mem_addr_o, 32'h200); post();

        // Held flush blocks issue after its first cycle
        flush_i      = 1'b1;
        flush_addr_i = 32'h0000_0300;
        step();
        g0 = n_grants;
        run(2);
        chk("held_flush_no_grant", 32'(n_grants - g0), 32'd0);
        flush_i = 1'b0;
        wait_req("held_release_req");
        chk("held_release_addr", mem_addr_o, 32'h300);
        post();

        // Fetch address wrap, with unaligned target bits dropped
        flush_i      = 1'b1;
        flush_addr_i = 32'hFFFF_FFFE;
        step();
        flush_i = 1'b0;
        wait_req("wrap_req");
        chk("wrap_top_addr", mem_addr_o, 32'hFFFF_FFFC);
        post();
        pre(); chk1("wrap_req2", mem_req_o, 1'b1); chk("wrap_zero_addr", mem_addr_o, 32'h0); post();
        run(6);

        // Asynchronous reset with three buffered entries
        do_reset();
        inst_ready_i = 1'b0;
        run(4);
        mem_gnt_i = 1'b0;
        step();
        pre();
        chk1("t6_pre_valid", inst_valid_o, 1'b1);
        chk1("t6_pre_req", mem_req_o, 1'b1);
        rst = 1'b1;
        #1;
        chk1("t6_async_valid", inst_valid_o, 1'b0);
        chk1("t6_async_req", mem_req_o, 1'b0);
        chk("t6_async_inst", inst_o, NOP);
        do_reset();
        mem_gnt_i    = 1'b1;
        inst_ready_i = 1'b1;
        pre(); chk1("t6_boot_no_req", mem_req_o, 1'b0); post();
        pre(); chk1("t6_refetch_req", mem_req_o, 1'b1); chk("t6_refetch_addr", mem_addr_o, 32'h0); post();
        run(6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
